dp_sequencer: RTL and testbench
===============================

# dp_sequencer

Sequencing controller for one dot-product lane. On a `start` handshake it latches a pixel vector and a weight vector and walks them one element at a time through an externally instantiated `FixedPointMultiplier` and `FixedPointAdder`. It waits out each unit's fixed latency, accumulates the running sum, and presents the final value with a one-cycle `done` pulse. Parallel lanes are built by instantiating several `dp_sequencer` blocks and summing their `value` outputs in the parent.

## Interface
- `PIXEL_N`, 10: elements per job.
- `PIXEL_SIZE`, 10: pixel width.
- `WEIGHT_SIZE`, 19: weight width.
- `VAL_SIZE`, 26: product/sum width.
- `FPM_DELAY`, 6: multiplier latency, cycles from operand registered to result valid (≥1).
- `FPA_DELAY`, 2: adder latency, same definition (≥1).

Ports:
- `clk` in 1: sole clock, rising edge.
- `GlobalReset` in 1: asynchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `Pixels` in PIXEL_N*PIXEL_SIZE: element i at bits [i*PIXEL_SIZE +: PIXEL_SIZE].
- `Weights` in PIXEL_N*WEIGHT_SIZE: element i at bits [i*WEIGHT_SIZE +: WEIGHT_SIZE].
- `mult_weight` out WEIGHT_SIZE: registered, to FPM `WeightPort`.
- `mult_pixel` out PIXEL_SIZE: registered, to FPM `PixelPort`.
- `mult_result` in VAL_SIZE: FPM `Output_syn`.
- `add_a` out VAL_SIZE: registered, to FPA `Port1` (accumulator).
- `add_b` out VAL_SIZE: registered, to FPA `Port2` (product).
- `add_result` in VAL_SIZE: FPA `Output_syn`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `value` out VAL_SIZE: last completed dot product.

## Operation
- States: IDLE, MULT, MULT_W, ADD, ADD_W, DONE.
- IDLE, `start`=1: latch `Pixels`/`Weights` into internal registers, set idx=0, acc=0, go to MULT. `start` is ignored in every other state.
- MULT: register `mult_weight`/`mult_pixel` from latched element idx, clear the wait counter, go to MULT_W.
- MULT_W: stay exactly FPM_DELAY cycles. On the last cycle capture `mult_result` into prod, then go to ADD.
- ADD: register `add_a`=acc and `add_b`=prod, clear the wait counter, go to ADD_W.
- ADD_W: stay exactly FPA_DELAY cycles. On the last cycle set acc←`add_result`.
  - If idx==PIXEL_N-1: `value`←`add_result`, go to DONE.
  - Otherwise: idx←idx+1, go to MULT.
- DONE: one cycle, then IDLE.
- Outputs:
  - `busy`=1 in MULT..ADD_W.
  - `done`=1 only in DONE.
  - `value` holds until the next job completes.
  - Operand outputs hold their last values between jobs.
- Arithmetic: no saturation or rounding in this block. It forwards whatever width and format the FPM/FPA produce. The accumulator is VAL_SIZE bits wide and reset to 0 at every job start.
- Live inputs: changes on `Pixels`/`Weights` after acceptance have no effect on the running job.
- Reset mid-job: everything returns to reset values, state goes to IDLE, no `done` is emitted, and the partial result is discarded.
- Reset values: all outputs 0, state IDLE, idx/acc/prod/counters 0.

## Timing
- Cycles per element: C = FPM_DELAY + FPA_DELAY + 2 (10 at defaults).
- Numbering: the accepting edge is edge 0.
- State sequence: the state is DONE after edge PIXEL_N*C, and `done` is high when sampled at edge PIXEL_N*C+1 (101 at defaults).
- Multiplier operands for element i change at edge i*C+1. `mult_result` is sampled at edge i*C+1+FPM_DELAY.
- `start` held high continuously: the next job is accepted at edge PIXEL_N*C+2, the first IDLE cycle after DONE. The minimum job-to-job period is therefore PIXEL_N*C+2.

## Structure
- Shared package `dp_pkg` holds:
  - the state encoding (distinct codes for all six states);
  - default delay constants FPM_DELAY_DEF=6 and FPA_DELAY_DEF=2;
  - a function computing C.
- Sub-module `dp_wait_counter`: load/clear, count, and `expire` flag at a programmed terminal count. It is instantiated once and reused for both wait states.
- FPM and FPA stay outside this block, in the parent lane wrapper.

## Test plan
- Reset: assert `GlobalReset` asynchronously mid-cycle → all outputs 0 immediately, IDLE.
- Defaults, behavioral FPM/FPA stubs honoring their delays, pixels=1..10, weights=2 → `value`=110, single `done` at edge 101, `busy` high edges 1–100.
- Mid-job interference: `start` pulsed and `Pixels` changed at edge 30 → ignored, result still 110, no extra `done`.
- Reset at edge 37 → outputs 0, no `done`; a fresh start then completes in 101 cycles with the correct value.
- `start` held high for 300 cycles → jobs accepted at edges 0, 102, 204; `done` high at edges 101, 203.
- Boundary PIXEL_N=1, FPM_DELAY=1, FPA_DELAY=1, pixel=3, weight=4 → `value`=12, `done` at edge 5.

Source files
------------

// File: rtl/dp_sequencer_pkg.sv
// dp_pkg: shared state encoding, default unit latencies and per-element cycle count for dp_sequencer
package dp_pkg;
  typedef enum logic [2:0] {IDLE, MULT, MULT_W, ADD, ADD_W, DONE} state_e;
  localparam int FPM_DELAY_DEF = 6;
  localparam int FPA_DELAY_DEF = 2;
  function automatic int cycles_per_elem(input int fpm, input int fpa);
    return fpm + fpa + 2;
  endfunction
endpackage

// File: rtl/dp_sequencer_if.sv
// dp_sequencer_if: operand/result bus between the sequencer and the external multiplier and adder
interface dp_sequencer_if #(
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int VAL_SIZE    = 26
);
  logic [WEIGHT_SIZE-1:0] mult_weight;
  logic [PIXEL_SIZE-1:0]  mult_pixel;
  logic [VAL_SIZE-1:0]    mult_result;
  logic [VAL_SIZE-1:0]    add_a;
  logic [VAL_SIZE-1:0]    add_b;
  logic [VAL_SIZE-1:0]    add_result;
  modport master (output mult_weight, mult_pixel, add_a, add_b, input mult_result, add_result);
  modport slave (input mult_weight, mult_pixel, add_a, add_b, output mult_result, add_result);
endinterface

// File: rtl/dp_sequencer_wait_counter.sv
// dp_wait_counter: clearable up-counter flagging the last cycle of a programmed wait
module dp_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign expire_o = en_i && (cnt_q == tc_i);
endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: one-lane dot-product controller walking latched vectors through an external multiplier and adder
module dp_sequencer import dp_pkg::*; #(
  parameter int PIXEL_N     = 10,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int VAL_SIZE    = 26,
  parameter int FPM_DELAY   = FPM_DELAY_DEF,
  parameter int FPA_DELAY   = FPA_DELAY_DEF
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  input  logic                           start,
  input  logic [PIXEL_N*PIXEL_SIZE-1:0]  Pixels,
  input  logic [PIXEL_N*WEIGHT_SIZE-1:0] Weights,
  dp_sequencer_if.master                 bus,
  output logic                           busy,
  output logic                           done,
  output logic [VAL_SIZE-1:0]            value
);
  localparam int IW = PIXEL_N > 1 ? $clog2(PIXEL_N) : 1;
  localparam int CW = $clog2((FPM_DELAY > FPA_DELAY ? FPM_DELAY : FPA_DELAY) + 1);

  state_e                         state_q, state_d;
  logic [PIXEL_N*PIXEL_SIZE-1:0]  pix_q, pix_d;
  logic [PIXEL_N*WEIGHT_SIZE-1:0] wgt_q, wgt_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [VAL_SIZE-1:0]            acc_q, acc_d, prod_q, prod_d, value_q, value_d;
  logic [VAL_SIZE-1:0]            add_a_q, add_a_d, add_b_q, add_b_d;
  logic [WEIGHT_SIZE-1:0]         mw_q, mw_d;
  logic [PIXEL_SIZE-1:0]          mp_q, mp_d;
  logic                           cnt_clr, cnt_en, expire;
  logic [CW-1:0]                  tc;

  // one counter serves both waits; its terminal count follows the current wait state
  assign tc = state_q == MULT_W ? CW'(FPM_DELAY - 1) : CW'(FPA_DELAY - 1);

  dp_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .rst      (GlobalReset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_i     (tc),
    .expire_o (expire)
  );

  always_ff @(posedge clk or posedge GlobalReset)
    if (GlobalReset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      wgt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      value_q <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      mw_q    <= '0;
      mp_q    <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      wgt_q   <= wgt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      value_q <= value_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      mw_q    <= mw_d;
      mp_q    <= mp_d;
    end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    wgt_d   = wgt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    value_d = value_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    mw_d    = mw_q;
    mp_d    = mp_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        pix_d   = Pixels;
        wgt_d   = Weights;
        idx_d   = '0;
        acc_d   = '0;
        state_d = MULT;
      end
      MULT: begin
        mw_d    = wgt_q[idx_q*WEIGHT_SIZE +: WEIGHT_SIZE];
        mp_d    = pix_q[idx_q*PIXEL_SIZE +: PIXEL_SIZE];
        cnt_clr = 1'b1;
        state_d = MULT_W;
      end
      MULT_W: begin
        cnt_en = 1'b1;
        if (expire) begin
          prod_d  = bus.mult_result;
          state_d = ADD;
        end
      end
      ADD: begin
        add_a_d = acc_q;
        add_b_d = prod_q;
        cnt_clr = 1'b1;
        state_d = ADD_W;
      end
      ADD_W: begin
        cnt_en = 1'b1;
        if (expire) begin
          acc_d   = bus.add_result;
          value_d = idx_q == IW'(PIXEL_N - 1) ? bus.add_result : value_q;
          idx_d   = idx_q == IW'(PIXEL_N - 1) ? idx_q : idx_q + 1'b1;
          state_d = idx_q == IW'(PIXEL_N - 1) ? DONE : MULT;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mult_weight = mw_q;
  assign bus.mult_pixel  = mp_q;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign busy            = state_q inside {MULT, MULT_W, ADD, ADD_W};
  assign done            = state_q == DONE;
  assign value           = value_q;
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: random and directed jobs on a default lane and a minimal lane, checked against a dot-product model
module tb_dp_sequencer;
  import dp_pkg::*;
  localparam int N  = 10;
  localparam int PS = 10;
  localparam int WS = 19;
  localparam int VS = 26;
  localparam int FA = FPM_DELAY_DEF;
  localparam int AA = FPA_DELAY_DEF;
  localparam int CA = cycles_per_elem(FA, AA);
  localparam int JA = N * CA + 1;
  localparam int JB = cycles_per_elem(1, 1) + 1;

  logic clk = 0, rst = 1, start_a = 0, start_b = 0;
  logic [N*PS-1:0] pix_a = '0;
  logic [N*WS-1:0] wgt_a = '0;
  logic [PS-1:0]   pix_b = '0;
  logic [WS-1:0]   wgt_b = '0;
  logic busy_a, done_a, busy_b, done_b;
  logic [VS-1:0] value_a, value_b;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dp_sequencer_if #(.PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .VAL_SIZE(VS)) ia ();
  dp_sequencer_if #(.PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .VAL_SIZE(VS)) ib ();

  dp_sequencer #(.PIXEL_N(N), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .VAL_SIZE(VS), .FPM_DELAY(FA), .FPA_DELAY(AA)) ua (
    .clk(clk), .GlobalReset(rst), .start(start_a), .Pixels(pix_a), .Weights(wgt_a),
    .bus(ia), .busy(busy_a), .done(done_a), .value(value_a));

  dp_sequencer #(.PIXEL_N(1), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS), .VAL_SIZE(VS), .FPM_DELAY(1), .FPA_DELAY(1)) ub (
    .clk(clk), .GlobalReset(rst), .start(start_b), .Pixels(pix_b), .Weights(wgt_b),
    .bus(ib), .busy(busy_b), .done(done_b), .value(value_b));

  // unit stubs: latency D means D-1 register stages after the registered operands
  logic [VS-1:0] mprod_a, asum_a;
  logic [VS-1:0] mpa [0:7];
  logic [VS-1:0] apa [0:7];
  assign mprod_a = VS'(ia.mult_pixel) * VS'(ia.mult_weight);
  assign asum_a  = ia.add_a + ia.add_b;
  always @(posedge clk) begin
    mpa[0] <= mprod_a;
    apa[0] <= asum_a;
    for (int k = 1; k < 8; k++) begin
      mpa[k] <= mpa[k-1];
      apa[k] <= apa[k-1];
    end
  end
  assign ia.mult_result = mpa[FA-2];
  assign ia.add_result  = apa[AA-2];
  assign ib.mult_result = VS'(ib.mult_pixel) * VS'(ib.mult_weight);
  assign ib.add_result  = ib.add_a + ib.add_b;

  logic [VS*3+WS+PS+1:0] outs_a, outs_b;
  assign outs_a = {busy_a, done_a, value_a, ia.mult_weight, ia.mult_pixel, ia.add_a, ia.add_b};
  assign outs_b = {busy_b, done_b, value_b, ib.mult_weight, ib.mult_pixel, ib.add_a, ib.add_b};

  function automatic logic [VS-1:0] dot(input logic [N*PS-1:0] p, input logic [N*WS-1:0] w, input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'(p[i*PS +: PS]) * longint'(w[i*WS +: WS]);
    return VS'(s);
  endfunction

  task automatic rand_vec(output logic [N*PS-1:0] p, output logic [N*WS-1:0] w);
    for (int i = 0; i < N; i++) begin
      p[i*PS +: PS] = PS'($urandom);
      w[i*WS +: WS] = WS'($urandom);
    end
  endtask

  task automatic run_a(input logic [N*PS-1:0] p, input logic [N*WS-1:0] w, input int hit, input string name);
    logic [VS-1:0] exp_v;
    int i;
    exp_v = dot(p, w, N);
    @(negedge clk);
    pix_a = p; wgt_a = w; start_a = 1;
    @(posedge clk);
    for (int e = 1; e <= JA + 1; e++) begin
      @(negedge clk);
      if (e == 1) start_a = 0;
      if (e == hit) begin start_a = 1; pix_a = ~p; end
      if (e == hit + 1) start_a = 0;
      checks++;
      if ({busy_a, done_a} !== {e < JA, e == JA}) begin
        errors++;
        $display("FAIL %s busy/done edge %0d got %b%b want %b%b", name, e, busy_a, done_a, e < JA, e == JA);
      end
      if (e >= 2 && e <= N*CA && (e - 2) % CA == 0) begin
        i = (e - 2) / CA;
        checks++;
        if ({ia.mult_pixel, ia.mult_weight} !== {p[i*PS +: PS], w[i*WS +: WS]}) begin
          errors++;
          $display("FAIL %s operands elem %0d got %h/%h want %h/%h", name, i, ia.mult_pixel, ia.mult_weight, p[i*PS +: PS], w[i*WS +: WS]);
        end
      end
    end
    checks++;
    if (value_a !== exp_v) begin
      errors++;
      $display("FAIL %s value got %0d want %0d", name, value_a, exp_v);
    end
  endtask

  task automatic run_b(input logic [PS-1:0] p, input logic [WS-1:0] w, input string name);
    logic [VS-1:0] exp_v;
    exp_v = VS'(longint'(p) * longint'(w));
    @(negedge clk);
    pix_b = p; wgt_b = w; start_b = 1;
    @(posedge clk);
    for (int e = 1; e <= JB + 1; e++) begin
      @(negedge clk);
      if (e == 1) start_b = 0;
      checks++;
      if ({busy_b, done_b} !== {e < JB, e == JB}) begin
        errors++;
        $display("FAIL %s busy/done edge %0d got %b%b want %b%b", name, e, busy_b, done_b, e < JB, e == JB);
      end
    end
    checks++;
    if (value_b !== exp_v) begin
      errors++;
      $display("FAIL %s value got %0d want %0d", name, value_b, exp_v);
    end
  endtask

  task automatic test_reset;
    logic [N*PS-1:0] p;
    logic [N*WS-1:0] w;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_a !== '0 || outs_b !== '0) begin
      errors++;
      $display("FAIL reset_values got %h/%h want 0", outs_a, outs_b);
    end
    rst = 0;
    rand_vec(p, w);
    p[PS-1:0] = PS'(7);
    @(negedge clk);
    pix_a = p; wgt_a = w; start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (ia.mult_pixel !== p[PS*2-1:PS] || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_prejob got pixel %h busy %b want %h 1", ia.mult_pixel, busy_a, p[PS*2-1:PS]);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (outs_a !== '0) begin
      errors++;
      $display("FAIL reset_async got %h want 0", outs_a);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic;
    logic [N*PS-1:0] p;
    logic [N*WS-1:0] w;
    for (int i = 0; i < N; i++) begin
      p[i*PS +: PS] = PS'(i + 1);
      w[i*WS +: WS] = WS'(2);
    end
    run_a(p, w, -1, "basic");
    checks++;
    if (value_a !== VS'(110)) begin
      errors++;
      $display("FAIL basic_110 got %0d want 110", value_a);
    end
  endtask

  task automatic test_interference;
    logic [N*PS-1:0] p;
    logic [N*WS-1:0] w;
    for (int i = 0; i < N; i++) begin
      p[i*PS +: PS] = PS'(i + 1);
      w[i*WS +: WS] = WS'(2);
    end
    run_a(p, w, 30, "interfere");
    repeat (5) @(negedge clk);
    checks++;
    if ({busy_a, done_a, value_a} !== {2'b00, VS'(110)}) begin
      errors++;
      $display("FAIL interfere_idle got %b%b %0d want 00 110", busy_a, done_a, value_a);
    end
  endtask

  task automatic test_reset_midjob;
    logic [N*PS-1:0] p;
    logic [N*WS-1:0] w;
    int bad;
    rand_vec(p, w);
    @(negedge clk);
    pix_a = p; wgt_a = w; start_a = 1;
    @(posedge clk);
    for (int e = 1; e < 37; e++) begin
      @(negedge clk);
      start_a = 0;
    end
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (outs_a !== '0) begin
      errors++;
      $display("FAIL midreset_outs got %h want 0", outs_a);
    end
    @(negedge clk);
    rst = 0;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_a || busy_a || value_a !== '0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_quiet got %0d active cycles want 0", bad);
    end
    rand_vec(p, w);
    run_a(p, w, -1, "after_reset");
  endtask

  task automatic test_random;
    logic [N*PS-1:0] p;
    logic [N*WS-1:0] w;
    for (int j = 0; j < 5; j++) begin
      rand_vec(p, w);
      run_a(p, w, -1, "random");
    end
  endtask

  task automatic test_back_to_back;
    logic [N*PS-1:0] p;
    logic [N*WS-1:0] w;
    int bad, m;
    bit seen;
    rand_vec(p, w);
    @(negedge clk);
    pix_a = p; wgt_a = w; start_a = 1;
    @(posedge clk);
    bad = 0;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      m = e % (JA + 1);
      checks++;
      if ({busy_a, done_a} !== {m >= 1 && m < JA, m == JA}) begin
        errors++;
        $display("FAIL b2b edge %0d got %b%b want %b%b", e, busy_a, done_a, m >= 1 && m < JA, m == JA);
      end
    end
    start_a = 0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = done_a;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_third_done got none want pulse");
    end
    checks++;
    if (value_a !== dot(p, w, N)) begin
      errors++;
      $display("FAIL b2b_value got %0d want %0d", value_a, dot(p, w, N));
    end
    @(negedge clk);
  endtask

  task automatic test_boundary;
    run_b(PS'(3), WS'(4), "boundary");
    checks++;
    if (value_b !== VS'(12)) begin
      errors++;
      $display("FAIL boundary_12 got %0d want 12", value_b);
    end
    for (int j = 0; j < 4; j++) run_b(PS'($urandom), WS'($urandom), "boundary_rand");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_interference;
    test_reset_midjob;
    test_random;
    test_back_to_back;
    test_boundary;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
